// File: rtl/rsa_rom_pkg.sv
// Shared definitions for the RSA constant ROM read path.
//   ROM_ADDR_W / ROM_DATA_W : geometry of the constant block ROMs
//   state_e                 : streamer control states
package rsa_rom_pkg;

  localparam int ROM_ADDR_W = 13;
  localparam int ROM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO used as the output skid buffer.
//   clk, rst      : clock, async active-high reset
//   push, din     : write side (push ignored when full)
//   pop, dout     : read side, dout shows the head entry (first-word fall-through)
//   count, empty  : occupancy
module sync_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head word reads as zero while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_word_streamer.sv
// Streams word_count consecutive words from a registered-output block ROM
// onto a valid/ready interface, absorbing the ROM read latency and
// downstream backpressure via a credit-limited skid FIFO.
//   clk, rst               : clock, async active-high reset
//   start, base_addr,
//   word_count             : command (sampled only in IDLE)
//   busy, done             : command status, done is a one-cycle pulse
//   rom_addr, rom_data     : ROM read port (1-cycle latency)
//   m_data, m_valid,
//   m_ready, m_last        : output stream
module rom_word_streamer
  import rsa_rom_pkg::*;
#(
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int DATA_W     = ROM_DATA_W,
  parameter int SKID_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);

  state_e            state;
  logic [ADDR_W:0]   issue_left;  // reads still to be issued
  logic              busy_q;
  logic              rd_vld;      // read issued last cycle, data on rom_data now
  logic              rd_last;     // that read was the final word
  logic              issue;
  logic              credit;
  logic              xfer;
  logic [CNT_W:0]    occ;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_dout;

  // Credit counts words buffered plus the read in flight; a pop in the same
  // cycle is deliberately not credited, which keeps the FIFO from ever
  // overflowing while still giving one word per cycle at depth 3.
  assign occ    = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_vld};
  assign credit = (occ < (CNT_W + 1)'(SKID_DEPTH));
  assign issue  = (state == FETCH) && credit;
  assign xfer   = m_valid && m_ready;

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_dout[DATA_W-1:0];
  assign m_last  = m_valid && fifo_dout[DATA_W];

  // busy also covers the cycle in which start is being accepted, so a
  // zero-length command still shows one busy cycle before its done pulse.
  assign busy = busy_q || ((state == IDLE) && start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      issue_left <= '0;
      busy_q     <= 1'b0;
      done       <= 1'b0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      rd_vld  <= issue;
      rd_last <= issue && (issue_left == (ADDR_W + 1)'(1));
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state      <= FETCH;
              rom_addr   <= base_addr;
              issue_left <= word_count;
              busy_q     <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            // Address wraps naturally at 2^ADDR_W.
            rom_addr   <= rom_addr + ADDR_W'(1);
            issue_left <= issue_left - (ADDR_W + 1)'(1);
            if (issue_left == (ADDR_W + 1)'(1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer && m_last) begin
            state  <= DONE;
            done   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The last-word flag travels with the data through the skid buffer.
  sync_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld),
    .din   ({rd_last, rom_data}),
    .pop   (xfer),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_rom_word_streamer.sv
module tb_rom_word_streamer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int SKID   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy, done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_ready, m_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Identity-content ROM with one-cycle registered output.
  always_ff @(posedge clk) rom_data <= DATA_W'(rom_addr);

  rom_word_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SKID_DEPTH(SKID)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_data(rom_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, m_valid, m_last} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b exp 0000", {busy, done, m_valid, m_last});
    end
    checks++;
    if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %h exp 0000", rom_addr); end
    checks++;
    if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h exp 0000", m_data); end
    @(posedge clk); #2; rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_basic();
    int ndone = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h0000; word_count = 14'd4; m_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; start = 1'b0; end
      @(negedge clk);
      if (done) ndone++;
      if (k <= 6) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy cyc %0d: got %b exp 1", k, busy); end
      end
      if (k >= 3 && k <= 6) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 16'(k - 3) || m_last !== (k == 6)) begin
          errors++;
          $display("FAIL basic_word cyc %0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   k, m_valid, m_data, m_last, 16'(k - 3), (k == 6));
        end
      end else begin
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid cyc %0d: got %b exp 0", k, m_valid); end
      end
      if (k == 7) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL basic_done cyc 7: got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
      end
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL basic_done_count: got %0d exp 1", ndone); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_addr [4];
    logic [DATA_W-1:0] d;
    exp_addr[0] = 13'h1FFE; exp_addr[1] = 13'h1FFF; exp_addr[2] = 13'h0000; exp_addr[3] = 13'h0001;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h1FFE; word_count = 14'd4; m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; start = 1'b0; end
      @(negedge clk);
      if (k >= 1 && k <= 4) begin
        checks++;
        if (rom_addr !== exp_addr[k-1]) begin
          errors++; $display("FAIL wrap_rom_addr cyc %0d: got %h exp %h", k, rom_addr, exp_addr[k-1]);
        end
      end
      if (k >= 3 && k <= 6) begin
        d = DATA_W'(exp_addr[k-3]);
        checks++;
        if (m_valid !== 1'b1 || m_data !== d || m_last !== (k == 6)) begin
          errors++;
          $display("FAIL wrap_word cyc %0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   k, m_valid, m_data, m_last, d, (k == 6));
        end
      end
    end
  endtask

  task automatic test_zero_count();
    int nvalid = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h0123; word_count = 14'd0; m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      // start is held into the DONE cycle; it must not be taken there.
      if (k == 2) begin @(posedge clk); #1; start = 1'b0; end
      else if (k > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (m_valid) nvalid++;
      if (k == 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_start: got %b exp 1", busy); end
      end
      if (k == 1) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL zero_done: got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
      end
      if (k >= 2) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL zero_after cyc %0d: got done=%b busy=%b exp 0 0", k, done, busy);
        end
      end
    end
    checks++;
    if (nvalid != 0) begin errors++; $display("FAIL zero_valid: got %0d valid cycles exp 0", nvalid); end
  endtask

  task automatic test_backpressure();
    logic [31:0]       pat = 32'hB4D2_6A39;
    int                n = 0;
    int                cyc = 0;
    bit                fin = 0;
    bit                stalled = 0;
    logic [DATA_W-1:0] held_d;
    logic              held_l;
    logic [ADDR_W-1:0] ahead;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h0010; word_count = 14'd16; m_ready = pat[0];
    while (!fin && cyc < 300) begin
      if (cyc > 0) begin @(posedge clk); #1; start = 1'b0; m_ready = pat[cyc % 32]; end
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held_d || m_last !== held_l) begin
          errors++;
          $display("FAIL bp_stable cyc %0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   cyc, m_valid, m_data, m_last, held_d, held_l);
        end
      end
      if (cyc >= 1 && !done) begin
        ahead = rom_addr - (13'h0010 + ADDR_W'(n));
        checks++;
        if (ahead > ADDR_W'(SKID)) begin
          errors++; $display("FAIL bp_ahead cyc %0d: got %0d exp <= %0d", cyc, ahead, SKID);
        end
      end
      stalled = m_valid && !m_ready;
      held_d  = m_data;
      held_l  = m_last;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 16'h0010 + 16'(n) || m_last !== (n == 15)) begin
          errors++;
          $display("FAIL bp_word %0d: got d=%h l=%b exp d=%h l=%b",
                   n, m_data, m_last, 16'h0010 + 16'(n), (n == 15));
        end
        n++;
      end
      if (done) fin = 1;
      cyc++;
    end
    checks++;
    if (!fin || n != 16) begin
      errors++; $display("FAIL bp_complete: got %0d words done=%0d exp 16 words done=1", n, fin);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n = 0, ndone = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h0020; word_count = 14'd5; m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = (k == 2);
        if (k == 2) begin base_addr = 13'h0100; word_count = 14'd3; end
      end
      @(negedge clk);
      if (done) ndone++;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 16'h0020 + 16'(n) || m_last !== (n == 4)) begin
          errors++;
          $display("FAIL busy_ignore_word %0d: got d=%h l=%b exp d=%h l=%b",
                   n, m_data, m_last, 16'h0020 + 16'(n), (n == 4));
        end
        n++;
      end
    end
    checks++;
    if (n != 5 || ndone != 1) begin
      errors++; $display("FAIL busy_ignore_count: got words=%0d dones=%0d exp 5 1", n, ndone);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h0040; word_count = 14'd8; m_ready = 1'b1;
    // Last issue in cycle 8, so cycle 9 is in DRAIN with words still queued.
    for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; start = 1'b0; end
    #2; rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, busy, m_last, done} !== 4'b0000 || rom_addr !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%b busy=%b l=%b done=%b addr=%h exp all 0",
               m_valid, busy, m_last, done, rom_addr);
    end
    @(posedge clk); #2; rst = 1'b0;
    idle_cycles(1);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h0080; word_count = 14'd2;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; start = 1'b0; end
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 16'h0080 + 16'(n) || m_last !== (n == 1)) begin
          errors++;
          $display("FAIL rst_mid_word %0d: got d=%h l=%b exp d=%h l=%b",
                   n, m_data, m_last, 16'h0080 + 16'(n), (n == 1));
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL rst_mid_count: got %0d exp 2", n); end
  endtask

  task automatic test_full_rom();
    int                n = 0, nlast = 0, bad = 0, cyc = 0;
    bit                fin = 0;
    logic [ADDR_W-1:0] a;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'h1234; word_count = 14'h2000; m_ready = 1'b1;
    while (!fin && cyc < 9000) begin
      if (cyc > 0) begin @(posedge clk); #1; start = 1'b0; end
      @(negedge clk);
      if (m_valid && m_ready) begin
        a = 13'h1234 + ADDR_W'(n);
        if (m_last) nlast++;
        if (m_data !== DATA_W'(a) || m_last !== (n == 8191)) begin
          if (bad == 0)
            $display("FAIL full_word %0d: got d=%h l=%b exp d=%h l=%b",
                     n, m_data, m_last, DATA_W'(a), (n == 8191));
          bad++;
        end
        n++;
      end
      if (done) fin = 1;
      cyc++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_data: got %0d bad words exp 0", bad); end
    checks++;
    if (!fin || n != 8192 || nlast != 1) begin
      errors++; $display("FAIL full_count: got words=%0d lasts=%0d done=%0d exp 8192 1 1", n, nlast, fin);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    idle_cycles(3);
    test_wrap();
    idle_cycles(3);
    test_zero_count();
    idle_cycles(3);
    test_backpressure();
    idle_cycles(3);
    test_back_to_back();
    idle_cycles(3);
    test_reset_mid();
    idle_cycles(3);
    test_full_rom();
    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
